// File: rtl/four_input_nor_tester_if.sv
`default_nettype none
// ============================================================================
// Module      : four_input_nor_tester_if
// Description : Bundle of the self-test sequencer's control, gate-drive and
//               result signals.
//                 start            - request a full sweep
//                 e                - output of the gate under test
//                 a,b,c,d          - gate inputs (vector bits 3..0)
//                 busy, done       - sweep in progress / end-of-sweep pulse
//                 pass, err_count,
//                 first_fail_vec,
//                 first_fail_valid - held results of the last sweep
//               master : the sequencer (drives the gate, reports results)
//               slave  : the board side (button, gate output, LEDs)
// Revision    : 1.0 - initial release
// ============================================================================
interface four_input_nor_tester_if;
    logic       start;
    logic       e;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;

    modport master (
        input  start, e,
        output a, b, c, d, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, e,
        input  a, b, c, d, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/four_input_nor_tester.sv
`default_nettype none
// ============================================================================
// Module      : four_input_nor_tester
// Description : Self-test sequencer for a 4-input NOR gate. Steps the gate
//               inputs through all 16 vectors, waits SETTLE_CYCLES clocks per
//               vector, samples e and compares it with ~(a|b|c|d). Reports a
//               mismatch count, the first failing vector and a pass flag.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - four_input_nor_tester_if.master (start, e, a..d,
//                       busy, done, pass, err_count, first_fail_vec,
//                       first_fail_valid)
// Parameters  : SETTLE_CYCLES - clocks between driving a vector and sampling
//                               e (1..15)
// Options     : NOR_TESTER_SYNC_EN - pass e through a two-flop synchronizer;
//                                    each vector then takes two extra clocks
// Revision    : 1.0 - initial release
// ============================================================================
module four_input_nor_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    four_input_nor_tester_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

`ifdef NOR_TESTER_SYNC_EN
    // The synchronizer delays e by two clocks, so the settle wait grows to match.
    localparam int c_EXTRA_WAIT = 2;
`else
    localparam int c_EXTRA_WAIT = 0;
`endif

    localparam logic [4:0] c_SETTLE_LAST = 5'(SETTLE_CYCLES + c_EXTRA_WAIT - 1);

    state_t     r_state,  w_state;
    logic [3:0] r_vec,    w_vec;
    logic [4:0] r_cnt,    w_cnt;
    logic [4:0] r_err,    w_err;
    logic [3:0] r_ffv,    w_ffv;
    logic       r_ffvalid, w_ffvalid;
    logic       r_pass,   w_pass;
    logic       r_done,   w_done;
    logic       r_busy,   w_busy;

    logic       w_e;
    logic       w_mismatch;

`ifdef NOR_TESTER_SYNC_EN
    logic [1:0] r_e_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_sync <= 2'b00;
        end else begin
            r_e_sync <= {r_e_sync[0], bus.e};
        end
    end

    assign w_e = r_e_sync[1];
`else
    assign w_e = bus.e;
`endif

    assign w_mismatch = (w_e != ~(|r_vec));

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_vec     <= 4'd0;
            r_cnt     <= 5'd0;
            r_err     <= 5'd0;
            r_ffv     <= 4'd0;
            r_ffvalid <= 1'b0;
            r_pass    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_vec     <= w_vec;
            r_cnt     <= w_cnt;
            r_err     <= w_err;
            r_ffv     <= w_ffv;
            r_ffvalid <= w_ffvalid;
            r_pass    <= w_pass;
            r_done    <= w_done;
            r_busy    <= w_busy;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_vec     = r_vec;
        w_cnt     = r_cnt;
        w_err     = r_err;
        w_ffv     = r_ffv;
        w_ffvalid = r_ffvalid;
        w_pass    = r_pass;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_vec = 4'd0;
                if (bus.start) begin
                    w_err     = 5'd0;
                    w_pass    = 1'b0;
                    w_ffv     = 4'd0;
                    w_ffvalid = 1'b0;
                    w_cnt     = 5'd0;
                    w_state   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                w_cnt = r_cnt + 5'd1;
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_mismatch) begin
                    // At most 16 mismatches, so 5 bits never overflow.
                    w_err = r_err + 5'd1;
                    if (!r_ffvalid) begin
                        w_ffv     = r_vec;
                        w_ffvalid = 1'b1;
                    end
                end
                if (r_vec == 4'hF) begin
                    w_state = S_DONE;
                end else begin
                    w_vec   = r_vec + 4'd1;
                    w_cnt   = 5'd0;
                    w_state = S_SETTLE;
                end
            end

            S_DONE: begin
                // r_err already includes any mismatch from the final CHECK.
                w_done  = 1'b1;
                w_pass  = (r_err == 5'd0);
                w_vec   = 4'd0;
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks SETTLE/CHECK.
        w_busy = (w_state == S_SETTLE) || (w_state == S_CHECK);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.a                = r_vec[3];
    assign bus.b                = r_vec[2];
    assign bus.c                = r_vec[1];
    assign bus.d                = r_vec[0];
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.err_count        = r_err;
    assign bus.first_fail_vec   = r_ffv;
    assign bus.first_fail_valid = r_ffvalid;

endmodule
`default_nettype wire

// File: doc/four_input_nor_tester.md
Name: four_input_nor_tester

Overview:
- Self-test sequencer that acts as the initiator side of a 4-input NOR gate under test.
- Drives all 16 input vectors onto a,b,c,d, waits a settle interval, then samples the gate output e.
- Compares each sample against the expected value ~(a|b|c|d) and reports an error count, the first failing vector and a pass flag.
- Sits beside the combinational gate on the lab board; start comes from a debounced button, results go to LEDs.

Parameters:
- SETTLE_CYCLES, 2, clocks between driving a vector and sampling e; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE.
- e  input  1  output of the gate under test.
- a  output  1  gate input, vector bit 3.
- b  output  1  gate input, vector bit 2.
- c  output  1  gate input, vector bit 1.
- d  output  1  gate input, vector bit 0.
- busy  output  1  high while a sweep is in progress (SETTLE/CHECK states).
- done  output  1  one-clock pulse at sweep end.
- pass  output  1  1 when the last sweep had zero mismatches; held.
- err_count  output  5  mismatches in the last sweep, 0..16; held.
- first_fail_vec  output  4  {a,b,c,d} of the first mismatching vector; held.
- first_fail_valid  output  1  first_fail_vec is meaningful; held.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n). All registers and outputs clear immediately on rst_n=0:
  - a..d=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
  - State = IDLE, vector register vec=0, wait counter=0.
- Output registration: all outputs are registered. a..d = vec[3:0].
- State machine: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - vec=0.
  - On start=1 at an edge: clear err_count, pass, first_fail_vec and first_fail_valid; load vec=0 and wait counter=0; go to SETTLE.
- SETTLE:
  - Wait counter increments each clock.
  - When the counter equals SETTLE_CYCLES-1, go to CHECK.
- CHECK (one clock):
  - Compare e with ~(vec[3]|vec[2]|vec[1]|vec[0]).
  - On mismatch: err_count+1. If first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec=15, go to DONE. Otherwise vec+1, wait counter=0, go to SETTLE.
- DONE (one clock):
  - done=1; pass=(final err_count==0), including a mismatch found in the last CHECK.
  - vec returns to 0; go to IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 clocks.
  - done is high in the clock starting 16*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start (49 for the default).
- Arithmetic: err_count is 5 bits and needs no saturation (maximum 16). vec wraps only by explicit return to 0 in DONE.
- Boundary conditions:
  - start while busy or in DONE: ignored. start held high across DONE: a new sweep begins from IDLE on the next edge.
  - Result outputs hold until the next accepted start or reset.
  - Reset mid-sweep: immediate return to reset values. No partial results are retained.
  - e is treated as synchronous to clk in the default build.

Optional Feature:
- NOR_TESTER_SYNC_EN defined:
  - e passes through a two-flop synchronizer before comparison.
  - SETTLE wait is extended by 2 clocks per vector; each vector occupies SETTLE_CYCLES+3 clocks.
  - done occurs 16*(SETTLE_CYCLES+3)+1 edges after start (81 for the default).
  - Synchronizer flops reset to 0.
- Not defined: e is compared directly; timing as in Behaviour.

Test Plan:
- Correct NOR model on e, SETTLE_CYCLES=2, pulse start:
  - a..d step 0000..1111 every 3 clocks.
  - done pulses exactly 49 edges after start.
  - pass=1, err_count=0, first_fail_valid=0.
- e stuck at 0 -> err_count=1, first_fail_vec=4'b0000, first_fail_valid=1, pass=0.
- e stuck at 1 -> err_count=15, first_fail_vec=4'b0001, pass=0.
- OR model (inverted) on e -> err_count=16, first_fail_vec=4'b0000, pass=0.
- Extra start pulse at cycle 10 of a sweep -> ignored, done still at edge 49.
- rst_n=0 at cycle 20 -> busy, a..d and err_count go to 0 without waiting for a clock edge. A following start produces a clean 49-cycle sweep.
- With NOR_TESTER_SYNC_EN and a correct model -> done at edge 81, pass=1, err_count=0.
